// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, status-register indices/ops and FIFO state encoding
package alu_pkg;

    localparam int DATA_W   = 20;
    localparam int SR_W     = 3;

    localparam int SR_CARRY = 0;
    localparam int SR_ZERO  = 1;
    localparam int SR_SIGN  = 2;

    localparam logic [1:0] SR_OP_NONE = 2'b00;
    localparam logic [1:0] SR_OP_LOAD = 2'b01;
    localparam logic [1:0] SR_OP_XOR  = 2'b10;
    localparam logic [1:0] SR_OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    function automatic logic [SR_W-1:0] sr_merge(input logic [SR_W-1:0] cur,
                                                 input logic [SR_W-1:0] flags,
                                                 input logic [SR_W-1:0] mask);
        return (cur & ~mask) | (flags & mask);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - 2-entry in-order writeback FIFO; tail view built only with WB_BYPASS_EN
module wb_fifo
    import alu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              tail_valid_o,
    output logic [ADDR_W-1:0] tail_addr_o,
    output logic [DATA_W-1:0] tail_data_o
);

    localparam int ENT_W = ADDR_W + DATA_W;

    fifo_state_e      state_q, state_d;
    logic             ready_q, ready_d;
    logic [ENT_W-1:0] slot0_q, slot0_d;
    logic [ENT_W-1:0] slot1_q, slot1_d;
    logic [ENT_W-1:0] in_entry;
    logic             push, pop;

    assign in_entry = {in_addr_i, in_data_i};
    assign push     = in_valid_i & ready_q;
    assign pop      = (state_q != FIFO_EMPTY) & out_ready_i;

    // slot0 is always the head; slot1 holds the younger entry only when FULL
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (state_q)
            FIFO_EMPTY: begin
                if (push) begin
                    state_d = FIFO_ONE;
                    slot0_d = in_entry;
                end
            end
            FIFO_ONE: begin
                if (push && pop) begin
                    slot0_d = in_entry;
                end else if (push) begin
                    state_d = FIFO_FULL;
                    slot1_d = in_entry;
                end else if (pop) begin
                    state_d = FIFO_EMPTY;
                end
            end
            FIFO_FULL: begin
                if (pop) begin
                    state_d = FIFO_ONE;
                    slot0_d = slot1_q;
                end
            end
            default: state_d = FIFO_EMPTY;
        endcase
        ready_d = (state_d != FIFO_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIFO_EMPTY;
            ready_q <= 1'b0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != FIFO_EMPTY);
    assign out_addr_o  = slot0_q[DATA_W +: ADDR_W];
    assign out_data_o  = slot0_q[DATA_W-1:0];

`ifdef WB_BYPASS_EN
    logic [ENT_W-1:0] tail;
    assign tail         = (state_q == FIFO_FULL) ? slot1_q : slot0_q;
    assign tail_valid_o = (state_q != FIFO_EMPTY);
    assign tail_addr_o  = tail[DATA_W +: ADDR_W];
    assign tail_data_o  = tail[DATA_W-1:0];
`else
    assign tail_valid_o = 1'b0;
    assign tail_addr_o  = '0;
    assign tail_data_o  = '0;
`endif

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU writeback: status register plus buffered RF write; forwarding via WB_BYPASS_EN
module alu_writeback
    import alu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_wr_en,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [SR_W-1:0]   in_flags,
    input  logic [SR_W-1:0]   in_flag_mask,
    input  logic [1:0]        in_sr_op,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ready,
    output logic [SR_W-1:0]   sr,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    logic            xfer;
    logic [SR_W-1:0] sr_q, sr_d;

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid & in_wr_en),
        .in_ready_o   (in_ready),
        .in_addr_i    (in_dest),
        .in_data_i    (in_result),
        .out_valid_o  (rf_we),
        .out_ready_i  (rf_ready),
        .out_addr_o   (rf_addr),
        .out_data_o   (rf_wdata),
        .tail_valid_o (fwd_valid),
        .tail_addr_o  (fwd_addr),
        .tail_data_o  (fwd_data)
    );

    // sr follows every accepted result, even ones that never reach the register file
    assign xfer = in_valid & in_ready;

    always_comb begin
        sr_d = sr_q;
        if (xfer) begin
            case (in_sr_op)
                SR_OP_LOAD: sr_d = in_result[SR_W-1:0];
                SR_OP_XOR:  sr_d = sr_q ^ in_result[SR_W-1:0];
                default:    sr_d = sr_merge(sr_q, in_flags, in_flag_mask);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr = sr_q;

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - randomized and directed bench for alu_writeback against a queue model
module tb_alu_writeback;

    localparam int AW = 4;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic          in_wr_en;
    logic [AW-1:0] in_dest;
    logic [2:0]    in_flags;
    logic [2:0]    in_flag_mask;
    logic [1:0]    in_sr_op;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic          rf_ready;
    logic [2:0]    sr;
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;

    alu_writeback #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_wr_en     (in_wr_en),
        .in_dest      (in_dest),
        .in_flags     (in_flags),
        .in_flag_mask (in_flag_mask),
        .in_sr_op     (in_sr_op),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_wdata     (rf_wdata),
        .rf_ready     (rf_ready),
        .sr           (sr),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data)
    );

    always #5 clk = ~clk;

    logic [AW+DW-1:0] mq[$];
    logic [2:0]       m_sr;
    logic             m_rdy;
    logic             chk_on = 1'b0;
    int               pass_cnt = 0;
    int               tot_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (chk_on) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
            check("rf_we", {31'd0, rf_we}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                e = mq[0];
                check("rf_addr", {28'd0, rf_addr}, {28'd0, e[DW +: AW]});
                check("rf_wdata", {12'd0, rf_wdata}, {12'd0, e[DW-1:0]});
            end
            check("sr", {29'd0, sr}, {29'd0, m_sr});
`ifdef WB_BYPASS_EN
            check("fwd_valid", {31'd0, fwd_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                e = mq[$];
                check("fwd_addr", {28'd0, fwd_addr}, {28'd0, e[DW +: AW]});
                check("fwd_data", {12'd0, fwd_data}, {12'd0, e[DW-1:0]});
            end
`else
            check("fwd_zero", {11'd0, fwd_valid, fwd_addr, fwd_data}, 32'd0);
`endif
        end
    end

    // one clock of the model: pending writes as a queue, sr by the plain update rules
    task automatic step();
        logic xfer, pop;
        xfer = in_valid && m_rdy;
        pop  = (mq.size() != 0) && rf_ready;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (xfer && in_wr_en) mq.push_back({in_dest, in_result});
        if (xfer) begin
            if (in_sr_op == 2'b01)      m_sr = in_result[2:0];
            else if (in_sr_op == 2'b10) m_sr = m_sr ^ in_result[2:0];
            else                        m_sr = (m_sr & ~in_flag_mask) | (in_flags & in_flag_mask);
        end
        m_rdy = (mq.size() < 2);
        #1;
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] d, input logic [DW-1:0] r,
                        input logic [1:0] op, input logic [2:0] fl, input logic [2:0] mk);
        logic done;
        done = 1'b0;
        in_valid = 1'b1; in_wr_en = wr; in_dest = d; in_result = r;
        in_sr_op = op; in_flags = fl; in_flag_mask = mk;
        for (int i = 0; i < 20 && !done; i++) begin
            done = m_rdy;
            step();
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mq.delete();
        m_sr  = 3'b000;
        m_rdy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; in_wr_en = 0; in_dest = 0; in_result = 0;
        in_flags = 0; in_flag_mask = 0; in_sr_op = 0; rf_ready = 0;
        do_reset();
        #2;
        chk_on = 1'b1;
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_sr", {29'd0, sr}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // single write drains next cycle
        rf_ready = 1'b1;
        send(1'b1, 4'd3, 20'h12345, 2'b00, 3'b000, 3'b000);
        check("lat_rf_we", {31'd0, rf_we}, 32'd1);
        check("lat_rf_addr", {28'd0, rf_addr}, 32'd3);
        check("lat_rf_wdata", {12'd0, rf_wdata}, 32'h12345);
        step();
        check("lat_empty", {31'd0, rf_we}, 32'd0);

        // back-pressure: three writes, third held until one pop
        rf_ready = 1'b0;
        send(1'b1, 4'd1, 20'hA0001, 2'b00, 3'b000, 3'b000);
        send(1'b1, 4'd2, 20'hA0002, 2'b00, 3'b000, 3'b000);
        check("full_not_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; in_wr_en = 1'b1; in_dest = 4'd4; in_result = 20'hA0003;
        step(); step();
        check("held_head", {28'd0, rf_addr}, 32'd1);
        rf_ready = 1'b1;
        step();
        check("order_2nd", {28'd0, rf_addr}, 32'd2);
        check("ready_again", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("order_3rd", {12'd0, rf_wdata}, 32'hA0003);
        step();
        check("drained", {31'd0, rf_we}, 32'd0);

        // status register rules
        send(1'b0, 4'd0, 20'h00005, 2'b01, 3'b000, 3'b000);
        check("sr_load", {29'd0, sr}, 32'b101);
        send(1'b0, 4'd0, 20'h00000, 2'b00, 3'b010, 3'b010);
        check("sr_mask", {29'd0, sr}, 32'b111);
        send(1'b0, 4'd0, 20'h00003, 2'b10, 3'b000, 3'b111);
        check("sr_xor", {29'd0, sr}, 32'b100);
        send(1'b0, 4'd0, 20'h00006, 2'b01, 3'b001, 3'b111);
        check("sr_load_nowr", {29'd0, sr}, 32'b110);
        check("nowr_no_rf_we", {31'd0, rf_we}, 32'd0);

        // reset with FIFO full
        rf_ready = 1'b0;
        send(1'b1, 4'd9, 20'hBEEF1, 2'b00, 3'b000, 3'b000);
        send(1'b1, 4'd10, 20'hBEEF2, 2'b00, 3'b000, 3'b000);
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2 do_reset();
        #1;
        check("midrst_rf_we", {31'd0, rf_we}, 32'd0);
        check("midrst_sr", {29'd0, sr}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_no_write", {31'd0, rf_we}, 32'd0);
        end

`ifdef WB_BYPASS_EN
        rf_ready = 1'b0;
        send(1'b1, 4'd5, 20'h00055, 2'b00, 3'b000, 3'b000);
        send(1'b1, 4'd7, 20'h00077, 2'b00, 3'b000, 3'b000);
        check("byp_youngest", {28'd0, fwd_addr}, 32'd7);
        rf_ready = 1'b1;
        step();
        check("byp_after_pop", {28'd0, fwd_addr}, 32'd7);
        step();
        check("byp_empty", {31'd0, fwd_valid}, 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_wr_en     = ($urandom_range(0, 3) != 0);
            in_dest      = AW'($urandom);
            in_result    = DW'($urandom);
            in_flags     = 3'($urandom);
            in_flag_mask = 3'($urandom);
            in_sr_op     = 2'($urandom);
            rf_ready     = ($urandom_range(0, 1) != 0);
            step();
        end
        in_valid = 1'b0;
        rf_ready = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
- REQ-001: Parameter ADDR_W, default 4, register-file address width.
- REQ-002: Parameter DATA_W, default 20, ALU result width; other values SHALL NOT be supported.
- REQ-003: clk  input  1  single clock; all state on posedge clk.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: in_valid  input  1  ALU result present.
- REQ-006: in_ready  output  1  block accepts the result this cycle.
- REQ-007: in_result  input  DATA_W  ALU result.
- REQ-008: in_wr_en  input  1  result is written to the register file.
- REQ-009: in_dest  input  ADDR_W  destination register.
- REQ-010: in_flags  input  3  ALU flags: [0]=carry, [1]=zero, [2]=sign.
- REQ-011: in_flag_mask  input  3  per-flag update enable.
- REQ-012: in_sr_op  input  2  00 none, 01 load SR, 10 XOR SR, 11 reserved (treated as 00).
- REQ-013: rf_we  output  1  write request to the register file.
- REQ-014: rf_addr  output  ADDR_W  write address.
- REQ-015: rf_wdata  output  DATA_W  write data.
- REQ-016: rf_ready  input  1  register file accepts the write this cycle.
- REQ-017: sr  output  3  status register; same bit order as in_flags.
- REQ-018: fwd_valid / fwd_addr / fwd_data  output  1 / ADDR_W / DATA_W  youngest pending write.

Function
- REQ-019: A transfer occurs when in_valid and in_ready are both high at a posedge.
- REQ-020: Buffering SHALL be a 2-entry in-order FIFO with states EMPTY, ONE and FULL.
- REQ-021: in_ready SHALL equal (state != FULL), registered only; it SHALL NOT depend combinationally on rf_ready.
- REQ-022: A transfer with in_wr_en=1 SHALL push {in_dest, in_result}; a transfer with in_wr_en=0 SHALL NOT push.
- REQ-023: rf_we SHALL be high when state != EMPTY; rf_addr and rf_wdata SHALL show the head entry; rf_we&rf_ready pops.
- REQ-024: Latency: a push into EMPTY SHALL appear on rf_we in the next cycle; there is no combinational in-to-rf path.
- REQ-025: State transitions:
  - push only: EMPTY->ONE, ONE->FULL.
  - pop only: FULL->ONE, ONE->EMPTY.
  - push with pop in ONE: stays ONE, with the new entry at the head next cycle.
- REQ-026: Push with pop is impossible in FULL per REQ-021; no entry SHALL ever be lost or duplicated.
- REQ-027: On a transfer with in_sr_op=01, sr SHALL become in_result[2:0] at the next posedge.
- REQ-028: On a transfer with in_sr_op=10, sr SHALL become sr ^ in_result[2:0].
- REQ-029: On a transfer with in_sr_op=00/11, each sr bit with its mask bit set SHALL take in_flags; unmasked bits SHALL hold.
- REQ-030: in_sr_op (when 01/10) SHALL take priority over in_flag_mask.
- REQ-031: sr SHALL update at transfer time regardless of FIFO occupancy or rf_ready.
- REQ-032: sr SHALL NOT change without a transfer.

Reset
- REQ-033: While rst_n is low: state=EMPTY, sr=3'b000, rf_we=0, fwd_valid=0, in_ready=0.
- REQ-034: in_ready SHALL rise in the first cycle after rst_n deasserts.
- REQ-035: Reset mid-operation SHALL discard all pending entries without issuing any register-file write.

Configuration
- REQ-036: With WB_BYPASS_EN defined, fwd_valid SHALL be high when state != EMPTY, and fwd_addr/fwd_data SHALL show the youngest (tail) entry.
- REQ-037: Without WB_BYPASS_EN, fwd_valid, fwd_addr and fwd_data SHALL be constant 0 and no bypass logic SHALL be built; ports remain present.

Structure
- REQ-038: Package alu_pkg SHALL hold: DATA_W, SR bit indices (SR_CARRY=0, SR_ZERO=1, SR_SIGN=2), SR op encodings and the FIFO state encoding.
- REQ-039: The FIFO SHALL be sub-module wb_fifo (2-entry, valid/ready both sides, tail visibility for bypass); sr logic SHALL stay in alu_writeback.

Verification
- REQ-040: Reset, then push dest=3, data=20'h12345, rf_ready=1 -> rf_we high on the next cycle with addr 3, data 20'h12345; EMPTY the cycle after.
- REQ-041: rf_ready=0, push three writes -> in_ready low after the second; the third is held until one pop; rf order is 1st, 2nd, 3rd.
- REQ-042: sr=3'b101; transfer with mask=3'b010, flags=3'b010 -> sr=3'b111; then sr_op=10 with result[2:0]=3'b011 -> sr=3'b100.
- REQ-043: Transfer with in_wr_en=0 and sr_op=01, result=20'h00006 -> sr=3'b110; no rf_we; FIFO occupancy unchanged.
- REQ-044: FIFO FULL, rf_ready=0, then assert rst_n=0 for one cycle -> rf_we=0 and sr=0 immediately; no write is issued after release.
- REQ-045: With WB_BYPASS_EN: push dest=5 then dest=7, rf_ready=0 -> fwd_addr=7; after one pop, fwd_addr stays 7; after the final pop, fwd_valid=0.
